// File: rtl/parity_stream_codec_if.sv
// Stream bundle for parity_stream_codec: encoder input, codeword output,
// receive-side checker input and error reporting. odd_mode is shared by
// both paths, so it travels with the bundle.
interface parity_stream_codec_if #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
);

  // shared parity mode
  logic              odd_mode;

  // encoder input stream
  logic              enc_valid;
  logic              enc_ready;
  logic [DATA_W-1:0] enc_data;

  // codeword output stream
  logic              cw_valid;
  logic              cw_ready;
  logic [DATA_W:0]   cw_data;

  // receive-side checker
  logic              chk_valid;
  logic [DATA_W:0]   chk_data;
  logic              clr_count;
  logic              err_pulse;
  logic [CNT_W-1:0]  err_count;

  // Producer / consumer / link side of the codec.
  modport master (
    output odd_mode,
    output enc_valid, enc_data,
    input  enc_ready,
    input  cw_valid, cw_data,
    output cw_ready,
    output chk_valid, chk_data, clr_count,
    input  err_pulse, err_count
  );

  // The codec itself.
  modport slave (
    input  odd_mode,
    input  enc_valid, enc_data,
    output enc_ready,
    output cw_valid, cw_data,
    input  cw_ready,
    input  chk_valid, chk_data, clr_count,
    output err_pulse, err_count
  );

endinterface

// File: rtl/parity_stream_codec.sv
// parity_stream_codec: registered parity encoder with a one-entry output
// register on a valid/ready stream, plus an independent receive-side checker
// that pulses on a bad codeword and keeps a saturating error count.
// Codeword layout is {parity, payload} with parity in the MSB.
module parity_stream_codec #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  parity_stream_codec_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Parity bit that makes the full codeword satisfy the selected mode.
  function automatic logic gen_parity(input logic [DATA_W-1:0] payload,
                                      input logic              odd);
    return (^payload) ^ odd;
  endfunction

  // High when a received codeword violates the selected mode.
  function automatic logic chk_parity_err(input logic [DATA_W:0] cw,
                                          input logic            odd);
    return (^cw) ^ odd;
  endfunction

  // ---------------------------------------------------------------------
  // Encoder path
  // ---------------------------------------------------------------------
  logic              cw_valid_q, cw_valid_d;
  logic [DATA_W:0]   cw_data_q,  cw_data_d;
  logic              enc_ready_s;
  logic              enc_accept_s;
  logic              cw_pop_s;

  // Handshake decode: the slot is free when empty or being drained this cycle.
  always_comb begin
    enc_ready_s  = ~cw_valid_q | bus.cw_ready;
    enc_accept_s = bus.enc_valid & enc_ready_s;
    cw_pop_s     = cw_valid_q & bus.cw_ready;
  end

  // Next state of the output register: push wins over pop, stall holds.
  always_comb begin
    cw_valid_d = cw_valid_q;
    cw_data_d  = cw_data_q;
    if (enc_accept_s) begin
      cw_valid_d = 1'b1;
      cw_data_d  = {gen_parity(bus.enc_data, bus.odd_mode), bus.enc_data};
    end else if (cw_pop_s) begin
      // Slot drains; payload is left as-is since it is don't-care when invalid.
      cw_valid_d = 1'b0;
      cw_data_d  = cw_data_q;
    end else begin
      cw_valid_d = cw_valid_q;
      cw_data_d  = cw_data_q;
    end
  end

  // Output register; reset drops any in-flight codeword.
  always_ff @(posedge clk) begin
    if (rst) begin
      cw_valid_q <= 1'b0;
      cw_data_q  <= {(DATA_W+1){1'b0}};
    end else begin
      cw_valid_q <= cw_valid_d;
      cw_data_q  <= cw_data_d;
    end
  end

  // ---------------------------------------------------------------------
  // Checker path
  // ---------------------------------------------------------------------
  logic              err_s;
  logic              err_pulse_q, err_pulse_d;
  logic [CNT_W-1:0]  err_count_q, err_count_d;

  // Error detect and counter update; clear beats a simultaneous error.
  always_comb begin
    err_s       = bus.chk_valid & chk_parity_err(bus.chk_data, bus.odd_mode);
    err_pulse_d = err_s;
    err_count_d = err_count_q;
    if (bus.clr_count) begin
      err_count_d = CNT_ZERO;
    end else if (err_s && (err_count_q != CNT_MAX)) begin
      err_count_d = err_count_q + CNT_ONE;
    end else begin
      err_count_d = err_count_q;
    end
  end

  // Checker registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_pulse_q <= 1'b0;
      err_count_q <= CNT_ZERO;
    end else begin
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs: all registered except enc_ready, which must see cw_ready
  // in the same cycle to sustain full rate.
  // ---------------------------------------------------------------------
  assign bus.enc_ready = enc_ready_s;
  assign bus.cw_valid  = cw_valid_q;
  assign bus.cw_data   = cw_data_q;
  assign bus.err_pulse = err_pulse_q;
  assign bus.err_count = err_count_q;

endmodule
